// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_sb register file and its scoreboard.
// Holds the FSM state encoding, the default widths and a helper that locates
// one port's field inside a packed multi-port bus.
package regfile_pkg;

    localparam logic CLEAR = 1'b0;
    localparam logic RUN   = 1'b1;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_CLEAR = CLEAR,
        ST_RUN   = RUN
    } state_e;

    // Lowest bit of port k's field in a bus of w-bit fields.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register entry, set by a reserve and
// cleared by a write. A same-address reserve beats the write because it
// belongs to a newer producer. Lookups return registered state only.
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    set_valid_i,
    input  logic [ADDR_W-1:0]       set_addr_i,
    input  logic                    clr_valid_i,
    input  logic [ADDR_W-1:0]       clr_addr_i,
    input  logic [NREAD*ADDR_W-1:0] raddr_i,
    output logic [NREAD-1:0]        rbusy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;

    // Next busy vector: clear first, then set, so the reserve wins on a tie.
    always_comb begin
        busy_d = busy_q;
        if (en_i && clr_valid_i) busy_d[clr_addr_i] = 1'b0;
        if (en_i && set_valid_i) busy_d[set_addr_i] = 1'b1;
        if (ZERO_REG != 0)       busy_d[0]          = 1'b0;
    end

    // Busy register; reset leaves every entry idle.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_look
        logic [ADDR_W-1:0] ra;
        assign ra         = raddr_i[lane_lo(k, ADDR_W) +: ADDR_W];
        assign rbusy_o[k] = en_i & busy_q[ra];
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with zero-register hardwiring, busy-bit
// scoreboard and a post-reset clear sequence (one entry per cycle).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to
// matching read ports; otherwise reads return stored contents only.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_addr,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREAD-1:0]        rbusy
);

    localparam int  DEPTH = 1 << ADDR_W;
    localparam bit  ZR    = (ZERO_REG != 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;

    // Nothing is accepted or visible until the clear walk has finished.
    assign ready = (state_q == ST_RUN) && !rst;
    assign wr_ok = ready && we && !(ZR && (waddr == '0));

    // Clear FSM next state: walk every index once, then run forever.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
        end
    end

    // Clear FSM registers; reset restarts the walk from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Data array: the clear walk owns the write port until RUN.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) mem_q[clr_idx_q] <= '0;
        else if (wr_ok)          mem_q[waddr]     <= wdata;
    end

    regfile_sb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (ready),
        .set_valid_i (rsv_valid),
        .set_addr_i  (rsv_addr),
        .clr_valid_i (we),
        .clr_addr_i  (waddr),
        .raddr_i     (raddr),
        .rbusy_o     (rbusy)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        assign ra = raddr[lane_lo(k, ADDR_W) +: ADDR_W];

        // Read mux: stored value, optional forward, then zero-reg and
        // not-ready overrides which take precedence over any forward.
        always_comb begin
            rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (we && (waddr == ra)) rd = wdata;
`else
            rd = mem_q[ra];
`endif
            if (ZR && (ra == '0)) rd = '0;
            if (!ready)           rd = '0;
        end

        assign rdata[lane_lo(k, DATA_W) +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (DATA_W=32, ADDR_W=5, NREAD=2, ZERO_REG=1).
// Expected values follow the build: REGFILE_BYPASS_EN selects forwarded data.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ready, we, rsv_valid;
    logic [4:0]  waddr, rsv_addr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ready(ready), .we(we), .waddr(waddr),
        .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rv;
        logic [4:0]  ra_rsv;
        logic [4:0]  r0, r1;
        logic [31:0] d0, d1;
        logic        b0, b1;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    vec_t tbl[17];
    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd,
                                logic rv, logic [4:0] rsa, logic [4:0] r0,
                                logic [4:0] r1, logic [31:0] d0,
                                logic [31:0] d1, logic b0, logic b1);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.rv = rv; v.ra_rsv = rsa;
        v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [31:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard-empty got=%h", act);
        end else begin
            e = q.pop_front();
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.nm, act, e.v);
            end
        end
    endtask

    task automatic idle_inputs;
        we = 0; waddr = 0; wdata = 0; rsv_valid = 0; rsv_addr = 0; raddr = 0;
    endtask

    // Counts cycles from rst falling until ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic check_all_zero(input string nm);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            #1;
            push({nm, "-d0"}, 32'h0);
            push({nm, "-d1"}, 32'h0);
            push({nm, "-busy"}, 32'h0);
            pop_cmp(rdata[31:0]);
            pop_cmp(rdata[63:32]);
            pop_cmp({30'h0, rbusy});
        end
    endtask

    initial begin
        int n;
        tbl[0]  = mk(1, 1, 32'hDEADBEEF, 0, 0, 1, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 32'h12345678, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[2]  = mk(0, 0, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[3]  = mk(1, 5, 32'hA5A5A5A5, 0, 0, 5, 5, BYP ? 32'hA5A5A5A5 : 32'h0,
                     BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0);
        tbl[4]  = mk(0, 5, 32'h11111111, 0, 0, 5, 1, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0);
        tbl[5]  = mk(0, 0, 32'h0,        1, 7, 7, 7, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 32'h0,        0, 0, 7, 3, 0, 0, 1, 0);
        tbl[7]  = mk(1, 7, 32'h77,       0, 0, 7, 7, BYP ? 32'h77 : 32'h0,
                     BYP ? 32'h77 : 32'h0, 1, 1);
        tbl[8]  = mk(0, 0, 32'h0,        0, 0, 7, 3, 32'h77, 0, 0, 0);
        tbl[9]  = mk(1, 7, 32'h88,       1, 7, 7, 3, BYP ? 32'h88 : 32'h77, 0, 0, 0);
        tbl[10] = mk(0, 0, 32'h0,        0, 0, 7, 7, 32'h88, 32'h88, 1, 1);
        tbl[11] = mk(1, 9, 32'h99,       1, 0, 0, 9, 0, BYP ? 32'h99 : 32'h0, 0, 0);
        tbl[12] = mk(0, 0, 32'h0,        0, 0, 0, 9, 0, 32'h99, 0, 0);
        tbl[13] = mk(1, 7, 32'hAA,       1, 9, 7, 9, BYP ? 32'hAA : 32'h88, 32'h99, 1, 0);
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 7, 9, 32'hAA, 32'h99, 0, 1);
        tbl[15] = mk(1, 1, 32'h12,       0, 0, 1, 2, BYP ? 32'h12 : 32'hDEADBEEF, 0, 0, 0);
        tbl[16] = mk(0, 0, 32'h0,        0, 0, 1, 2, 32'h12, 0, 0, 0);

        idle_inputs();
        rst = 1;
        tick();
        push("ready-in-reset", 32'h0);
        pop_cmp({31'h0, ready});

        // Initial clear with writes/reserves attempted; they must be dropped.
        rst = 0;
        we = 1; waddr = 3; wdata = 32'hFF; rsv_valid = 1; rsv_addr = 4;
        wait_ready(n);
        idle_inputs();
        push("clear-cycles", 32'd32);
        pop_cmp(32'(n));
        check_all_zero("ignore-before-ready");

        // Table-driven run-mode vectors, one cycle each.
        foreach (tbl[i]) begin
            we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
            rsv_valid = tbl[i].rv; rsv_addr = tbl[i].ra_rsv;
            raddr = {tbl[i].r1, tbl[i].r0};
            push($sformatf("v%0d-d0", i), tbl[i].d0);
            push($sformatf("v%0d-d1", i), tbl[i].d1);
            push($sformatf("v%0d-busy", i), {30'h0, tbl[i].b1, tbl[i].b0});
            #3;
            pop_cmp(rdata[31:0]);
            pop_cmp(rdata[63:32]);
            pop_cmp({30'h0, rbusy});
            tick();
        end
        idle_inputs();

        // Reset with preloaded data and busy bits.
        rst = 1;
        tick();
        rst = 0;
        wait_ready(n);
        push("reclear-cycles", 32'd32);
        pop_cmp(32'(n));
        check_all_zero("after-reclear");

        // Reset again at clear cycle 10: walk restarts from 0.
        rst = 1;
        tick();
        rst = 0;
        repeat (10) tick();
        push("ready-mid-clear", 32'h0);
        pop_cmp({31'h0, ready});
        rst = 1;
        tick();
        rst = 0;
        wait_ready(n);
        push("restart-cycles", 32'd32);
        pop_cmp(32'(n));
        check_all_zero("after-restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
